piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 transmits bit WIDTH-1 first and 0 transmits bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port in_data, input, WIDTH bits, the parallel word to serialize.
REQ-006 The block SHALL have port in_valid, input, 1 bit, asserted when in_data holds a word to send.
REQ-007 The block SHALL have port in_ready, output, 1 bit, asserted when the block will accept a word at the next rising edge.
REQ-008 The block SHALL have port sout, output, 1 bit, the serial data bit.
REQ-009 The block SHALL have port sout_valid, output, 1 bit, asserted while sout carries a word bit.
REQ-010 The block SHALL have port sof, output, 1 bit, asserted only while sout carries the first bit of a word.
REQ-011 The block SHALL have port busy, output, 1 bit, asserted whenever the FSM is in SHIFT.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and SHIFT, with a WIDTH-bit shift register sr and a bit counter cnt of width $clog2(WIDTH).
REQ-013 in_ready SHALL be 1 in IDLE, 1 in SHIFT when cnt==WIDTH-1, and 0 otherwise; it SHALL depend only on registered state, never combinationally on in_valid.
REQ-014 A word SHALL be accepted at a rising edge where in_valid and in_ready are both 1; on acceptance sr<=in_data, cnt<=0, state<=SHIFT.
REQ-015 In SHIFT with no acceptance, each edge SHALL shift sr by one position toward the transmit end, increment cnt, and go to IDLE when cnt==WIDTH-1.
REQ-016 sout SHALL equal sr[WIDTH-1] when MSB_FIRST=1 and sr[0] when MSB_FIRST=0, and SHALL be driven 0 in IDLE.
REQ-017 sout_valid and busy SHALL be 1 exactly when the state is SHIFT; sof SHALL be 1 exactly when the state is SHIFT and cnt==0.
REQ-018 Latency: for a word accepted at edge k, bit i (in transmit order, i=0..WIDTH-1) SHALL be on sout in the cycle between edges k+i and k+i+1.
REQ-019 Back-to-back: acceptance at the edge ending the last bit (cnt==WIDTH-1) SHALL reload sr and restart at cnt=0 with no idle cycle, so sout_valid stays continuously 1.
REQ-020 in_valid while in_ready=0 SHALL be ignored with no state change, and in_data SHALL be sampled only at the acceptance edge.
REQ-021 The shift fill bit SHALL be 0.

Reset
REQ-022 When rst=0 at a rising edge, the block SHALL set state=IDLE, sr=0 and cnt=0, which forces sout=0, sout_valid=0, sof=0, busy=0 and in_ready=1 from the next cycle.
REQ-023 Reset SHALL take priority over acceptance and shifting; a word in flight SHALL be aborted and never resumed.
REQ-024 An acceptance handshake presented at the same edge as an active reset SHALL be discarded.

Verification
REQ-025 Bench: WIDTH=8, MSB_FIRST=1, send 0xA5 -> sout over 8 consecutive cycles = 1,0,1,0,0,1,0,1; sof=1 only on the first; sout_valid=1 for exactly 8 cycles; busy then falls.
REQ-026 Bench: 0xA5 then 0x3C, with in_valid held continuously -> 16 contiguous sout_valid cycles; bit stream 10100101 00111100; sof=1 in cycles 0 and 8.
REQ-027 Bench: MSB_FIRST=0, send 0x01 -> sout = 1,0,0,0,0,0,0,0.
REQ-028 Bench: rst=0 asserted after 3 bits of 0xFF -> from the next cycle all outputs = 0 and in_ready=1; a new word 0x80 then transmits cleanly as 1 followed by seven 0s.
REQ-029 Bench: in_data changed and in_valid=1 during bits 1..6 of a word -> the change is ignored and the current word is unchanged.
REQ-030 Bench: loopback of sout, gated by sout_valid, into the team's 8-bit serial-in shift register (shifting left, serial bit into bit 0) for random words -> the received byte equals the sent byte after 8 bits.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word on a valid/ready
// handshake and streams it one bit per clock, with back-to-back reload on the last bit.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;

  // Move the register one place toward the transmit end, filling with 0.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Ready is a function of registered state only, so it never loops back through in_valid.
  assign in_ready = (state_q == IDLE) || last_bit;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      sr_d    = in_data;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      sr_d = shift_out(sr_q);
      if (last_bit) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign sout_valid = (state_q == SHIFT);
  assign sof        = (state_q == SHIFT) && (cnt_q == '0);
  assign sout       = (state_q == SHIFT) ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : 1'b0;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first instance and an LSB-first instance
// on a shared clock/reset, with a serial-in shift register receiving the MSB-first stream.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, sout, sout_valid, sof, busy;
  logic [7:0] in_data1;
  logic       in_valid1;
  logic       in_ready1, sout1, sout_valid1, sof1, busy1;
  logic [7:0] rx;

  int passes = 0;
  int total  = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sout(sout), .sout_valid(sout_valid), .sof(sof), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sout(sout1), .sout_valid(sout_valid1), .sof(sof1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver: shift left, serial bit into bit 0, only while a bit is valid.
  always_ff @(posedge clk) begin
    if (sout_valid) rx <= {rx[6:0], sout};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sout"}, sout, 0);
    chk({tag, "_svalid"}, sout_valid, 0);
    chk({tag, "_sof"}, sof, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  // Send one word on the MSB-first instance and check each transmitted bit against exp_bits.
  task automatic run_word(input string tag, input logic [7:0] w, input logic [7:0] exp_bits);
    in_data  = w;
    in_valid = 1'b1;
    chk({tag, "_ready0"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), sout, exp_bits[7-i]);
      chk($sformatf("%s_vld%0d", tag, i), sout_valid, 1);
      chk($sformatf("%s_sof%0d", tag, i), sof, (i == 0));
      chk($sformatf("%s_busy%0d", tag, i), busy, 1);
      step();
    end
    chk({tag, "_end_vld"}, sout_valid, 0);
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    logic [15:0] stream;
    logic [7:0]  lsb_exp;
    logic [7:0]  w;

    rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_data1 = 8'h00; in_valid1 = 1'b0;
    step();
    step();
    chk_idle("reset");
    chk("reset_lsb_vld", sout_valid1, 0);
    chk("reset_lsb_ready", in_ready1, 1);
    rst = 1'b1;
    step();

    // Single word 0xA5, MSB first.
    run_word("a5", 8'hA5, 8'b1010_0101);

    // Back-to-back 0xA5 then 0x3C with in_valid held high.
    stream   = 16'b1010_0101_0011_1100;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    in_data = 8'h3C;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("b2b_bit%0d", c), sout, stream[15-c]);
      chk($sformatf("b2b_vld%0d", c), sout_valid, 1);
      chk($sformatf("b2b_sof%0d", c), sof, (c % 8 == 0));
      chk($sformatf("b2b_rdy%0d", c), in_ready, (c % 8 == 7));
      if (c == 8) in_valid = 1'b0;
      step();
    end
    chk("b2b_end_vld", sout_valid, 0);
    chk("b2b_end_busy", busy, 0);

    // LSB-first instance sending 0x01.
    lsb_exp   = 8'b1000_0000;
    in_data1  = 8'h01;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_bit%0d", i), sout1, lsb_exp[7-i]);
      chk($sformatf("lsb_vld%0d", i), sout_valid1, 1);
      chk($sformatf("lsb_sof%0d", i), sof1, (i == 0));
      chk($sformatf("lsb_busy%0d", i), busy1, 1);
      step();
    end
    chk("lsb_end_vld", sout_valid1, 0);

    // Abort 0xFF after three bits with reset.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_bit%0d", i), sout, 1);
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_idle("abort");
    step();
    chk_idle("abort_hold");

    // Handshake at the same edge as reset must be discarded.
    rst      = 1'b0;
    in_data  = 8'hC3;
    in_valid = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_idle("rst_hs");
    rst = 1'b1;
    step();
    chk_idle("rst_hs_after");

    // Clean restart after abort.
    run_word("w80", 8'h80, 8'b1000_0000);

    // Data/valid changes mid-word are ignored.
    in_data  = 8'h5A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    w = 8'b0101_1010;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("ign_bit%0d", c), sout, w[7-c]);
      if (c >= 1 && c <= 6) begin
        chk($sformatf("ign_rdy%0d", c), in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'(8'hFF - 8'(c));
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    chk("ign_end_vld", sout_valid, 0);

    // Loopback into the serial-in receiver with random words.
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom_range(0, 255));
      run_word($sformatf("lb%0d", k), w, w);
      chk($sformatf("lb%0d_rx", k), rx, w);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
